// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage and the control decoder:
//   - fetch FSM state encoding
//   - PC / ROM address / jump-target widths
//   - 5-bit opcode constants (insn[31:27]) understood by the control decoder
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

   localparam int PC_W     = 32;
   localparam int ADDR_W   = 12;
   localparam int TARGET_W = 27;
   localparam int INSN_W   = 32;
   localparam int OP_W     = 5;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b00101;
   localparam logic [OP_W-1:0] OP_LW   = 5'b01000;
   localparam logic [OP_W-1:0] OP_SW   = 5'b00111;
   localparam logic [OP_W-1:0] OP_J    = 5'b00001;
   localparam logic [OP_W-1:0] OP_BNE  = 5'b00010;
   localparam logic [OP_W-1:0] OP_JAL  = 5'b00011;
   localparam logic [OP_W-1:0] OP_JR   = 5'b00100;
   localparam logic [OP_W-1:0] OP_BLT  = 5'b00110;
   localparam logic [OP_W-1:0] OP_BEX  = 5'b10110;
   localparam logic [OP_W-1:0] OP_SETX = 5'b10101;

   // Zero-extend a jump/branch target to a full PC.
   function automatic logic [PC_W-1:0] target_to_pc(input logic [TARGET_W-1:0] t);
      return {{(PC_W-TARGET_W){1'b0}}, t};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundle of everything the fetch stage exchanges with the rest of the core:
//   control in : stall, redirect, redirect_target
//   ROM bus    : imem_addr (out), imem_q (in, one cycle after imem_addr)
//   decode out : insn_out, opcode_out, pc_out, pc_plus1, valid_out, fetch_count
// master = fetch stage side, slave = surrounding core / ROM side.
// -----------------------------------------------------------------------------
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic                stall;
   logic                redirect;
   logic [TARGET_W-1:0] redirect_target;
   logic [ADDR_W-1:0]   imem_addr;
   logic [INSN_W-1:0]   imem_q;
   logic [INSN_W-1:0]   insn_out;
   logic [OP_W-1:0]     opcode_out;
   logic [PC_W-1:0]     pc_out;
   logic [PC_W-1:0]     pc_plus1;
   logic                valid_out;
   logic [PC_W-1:0]     fetch_count;

   modport master (
      input  stall, redirect, redirect_target, imem_q,
      output imem_addr, insn_out, opcode_out, pc_out, pc_plus1, valid_out, fetch_count
   );

   modport slave (
      output stall, redirect, redirect_target, imem_q,
      input  imem_addr, insn_out, opcode_out, pc_out, pc_plus1, valid_out, fetch_count
   );

endinterface

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// PC / state registers and next-PC selection for the fetch stage.
//   clock, reset     : system clock, async active-low reset
//   stall            : decode not accepting; hold the displayed instruction
//   redirect         : load redirect_target as next fetch PC (beats stall)
//   redirect_target  : 27-bit target, zero-extended
//   imem_addr        : ROM address for this cycle
//   pc_d             : PC of the instruction currently on imem_q
//   valid            : high in RUN
//   count_en         : an instruction is accepted by decode this cycle
// pc_f is the next PC to fetch; pc_d trails it by one once RUN is reached.
// -----------------------------------------------------------------------------
module fetch_pc_reg
   import fetch_stage_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                redirect,
   input  logic [TARGET_W-1:0] redirect_target,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [PC_W-1:0]     pc_d,
   output logic                valid,
   output logic                count_en
);

   fetch_state_t    state, state_nx;
   logic [PC_W-1:0] pc_f, pc_f_nx, pc_d_nx;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= FILL;
         pc_f  <= '0;
         pc_d  <= '0;
      end else begin
         state <= state_nx;
         pc_f  <= pc_f_nx;
         pc_d  <= pc_d_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      pc_f_nx   = pc_f;
      pc_d_nx   = pc_d;
      imem_addr = pc_f[ADDR_W-1:0];
      valid     = 1'b0;
      count_en  = 1'b0;

      case (state)
         FILL: begin
            // stall is ignored: nothing valid is on display yet
            pc_d_nx  = pc_f;
            pc_f_nx  = pc_f + 32'd1;
            state_nx = RUN;
         end
         RUN: begin
            valid = 1'b1;
            if (stall) begin
               // re-read the displayed PC so the ROM output stays put
               imem_addr = pc_d[ADDR_W-1:0];
            end else begin
               pc_d_nx  = pc_f;
               pc_f_nx  = pc_f + 32'd1;
               count_en = 1'b1;
            end
         end
         default: state_nx = FILL;
      endcase

      // Redirect overrides the PC/state update only; this cycle's outputs
      // and the accept count are left as they are, and pc_d keeps its value.
      if (redirect) begin
         pc_f_nx  = target_to_pc(redirect_target);
         pc_d_nx  = pc_d;
         state_nx = FILL;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch for a synchronous-ROM core.
//   clock  : rising-edge system clock
//   reset  : asynchronous active-low reset
//   bus    : fetch_stage_if.master (stall/redirect in, ROM bus, decode outputs)
// The ROM has one cycle of read latency, so imem_q always belongs to pc_d.
// After reset or a redirect one FILL bubble precedes the first valid insn.
// fetch_count counts instructions accepted by decode and saturates.
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   fetch_stage_if.master bus
);

   logic [PC_W-1:0] pc_d;
   logic            valid;
   logic            count_en;
   logic [PC_W-1:0] fetch_count_q;

   function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   fetch_pc_reg u_pc_reg (
      .clock           (clock),
      .reset           (reset),
      .stall           (bus.stall),
      .redirect        (bus.redirect),
      .redirect_target (bus.redirect_target),
      .imem_addr       (bus.imem_addr),
      .pc_d            (pc_d),
      .valid           (valid),
      .count_en        (count_en)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_count_q <= '0;
      end else if (count_en) begin
         fetch_count_q <= sat_inc(fetch_count_q);
      end
   end

   assign bus.insn_out    = bus.imem_q;
   assign bus.opcode_out  = bus.imem_q[INSN_W-1 -: OP_W];
   assign bus.pc_out      = pc_d;
   assign bus.pc_plus1    = pc_d + 32'd1;
   assign bus.valid_out   = valid;
   assign bus.fetch_count = fetch_count_q;

endmodule
